// File: rtl/run_controller.sv
// Run-control sequencer: owns the instruction phase counter and the PC/IR/AC
// clock enable, and handles run/stop/step, HLT, PC breakpoints and retired counts.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | stopped at an instruction boundary (or breakpoint), phase held
// RUN    | free-running, phase advances every cycle
// STEP   | executing up to the next instruction boundary, then IDLE
// HALTED | HLT seen at phase 4, phase parked at 5 until run/step/stop
module run_controller #(
  parameter int AW       = 5,
  parameter int CW       = 16,
  parameter int AUTO_RUN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          stop,
  input  logic          step,
  input  logic          halt,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc_addr,
  output logic [2:0]    phase,
  output logic          cpu_en,
  output logic [1:0]    state,
  output logic          halted,
  output logic          bp_hit,
  output logic [CW-1:0] instr_cnt
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_STEP   = 2'b10;
  localparam logic [1:0] S_HALTED = 2'b11;
  localparam logic [1:0] S_RESET  = (AUTO_RUN != 0) ? S_RUN : S_IDLE;

  logic          stop_pend;
  logic          bp_skip;
  logic [1:0]    state_nxt;
  logic          stop_pend_nxt;
  logic          bp_skip_nxt;
  logic          bp_hit_nxt;
  logic          advance;
  logic          boundary;
  logic          halt_now;
  logic          bp_now;

  assign cpu_en   = (state == S_RUN) || (state == S_STEP);
  assign halted   = (state == S_HALTED);
  assign boundary = cpu_en && (phase == 3'd7);
  assign halt_now = cpu_en && halt && (phase == 3'd4);
  // bp_skip lets a resume step past the breakpoint it just stopped on
  assign bp_now   = (state == S_RUN) && bp_en && (pc_addr == bp_addr) &&
                    (phase == 3'd0) && !bp_skip;

  always_comb begin
    state_nxt     = state;
    stop_pend_nxt = stop_pend;
    bp_skip_nxt   = bp_skip;
    bp_hit_nxt    = bp_hit;
    advance       = cpu_en;
    case (state)
      S_IDLE, S_HALTED: begin
        if (run) begin
          state_nxt   = S_RUN;
          bp_skip_nxt = 1'b1;
          bp_hit_nxt  = 1'b0;
        end else if (step) begin
          state_nxt   = S_STEP;
          bp_skip_nxt = 1'b1;
          bp_hit_nxt  = 1'b0;
        end else if (stop && (state == S_HALTED)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        if (phase == 3'd0) bp_skip_nxt = 1'b0;
        if (stop) stop_pend_nxt = 1'b1;
        if (halt_now) begin
          state_nxt = S_HALTED;
        end else if (boundary && ((state == S_STEP) || stop_pend || stop)) begin
          state_nxt     = S_IDLE;
          stop_pend_nxt = 1'b0;
        end else if (bp_now) begin
          state_nxt  = S_IDLE;
          bp_hit_nxt = 1'b1;
          advance    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RESET;
      phase     <= 3'd0;
      stop_pend <= 1'b0;
      bp_skip   <= 1'b1;
      bp_hit    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stop_pend <= stop_pend_nxt;
      bp_skip   <= bp_skip_nxt;
      bp_hit    <= bp_hit_nxt;
      if (advance) phase <= phase + 3'd1;
      if (boundary) instr_cnt <= instr_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed test-plan scenarios followed by random
// command traffic, all compared against a cycle-level behavioural model.
module tb_run_controller;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0, stop = 1'b0, step = 1'b0, halt = 1'b0, bp_en = 1'b0;
  logic [AW-1:0] bp_addr = '0, pc_addr = '0;
  logic [2:0]    phase;
  logic          cpu_en, halted, bp_hit;
  logic [1:0]    state;
  logic [CW-1:0] instr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: 0 idle, 1 run, 2 step, 3 halted
  int m_st, m_ph, m_cnt;
  bit m_hit, m_skip, m_pend;

  run_controller #(.AW(AW), .CW(CW), .AUTO_RUN(0)) dut (
    .clk(clk), .rst(rst), .run(run), .stop(stop), .step(step), .halt(halt),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_addr(pc_addr), .phase(phase),
    .cpu_en(cpu_en), .state(state), .halted(halted), .bp_hit(bp_hit),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_cnt = 0;
    m_hit = 0; m_skip = 1; m_pend = 0;
  endtask

  // one clock of the run-control rules, applied to the inputs seen at the edge
  task automatic model_step();
    bit running, at_end, bp;
    int nst;
    running = (m_st == 1) || (m_st == 2);
    if (!running) begin
      if (run)      begin m_st = 1; m_skip = 1; m_hit = 0; end
      else if (step) begin m_st = 2; m_skip = 1; m_hit = 0; end
      else if (stop && m_st == 3) m_st = 0;
      return;
    end
    at_end = (m_ph == 7);
    bp = (m_st == 1) && bp_en && (pc_addr == bp_addr) && (m_ph == 0) && !m_skip;
    nst = m_st;
    if (stop) m_pend = 1;
    if (halt && m_ph == 4) nst = 3;
    else if (at_end && (m_st == 2 || m_pend)) begin nst = 0; m_pend = 0; end
    else if (bp) begin nst = 0; m_hit = 1; end
    if (m_ph == 0) m_skip = 0;
    if (at_end) m_cnt = (m_cnt + 1) % (1 << CW);
    if (!(bp && nst == 0 && !(halt && m_ph == 4))) m_ph = (m_ph + 1) % 8;
    m_st = nst;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".state"},  int'(state),     m_st);
    chk({tag, ".phase"},  int'(phase),     m_ph);
    chk({tag, ".cpu_en"}, int'(cpu_en),    int'(m_st == 1 || m_st == 2));
    chk({tag, ".halted"}, int'(halted),    int'(m_st == 3));
    chk({tag, ".bp_hit"}, int'(bp_hit),    int'(m_hit));
    chk({tag, ".cnt"},    int'(instr_cnt), m_cnt);
  endtask

  // inputs are set at the falling edge; the model follows the rising edge
  task automatic tick(input string tag = "cyc");
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
    run = 0; stop = 0; step = 0; halt = 0;
  endtask

  int c0;

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    chk("reset.phase0", int'(phase), 0);
    @(negedge clk);
    rst = 1'b1;

    // free run: three instructions in 24 cycles
    run = 1; tick("run");
    chk("run.first_phase", int'(phase), 0);
    chk("run.cpu_en", int'(cpu_en), 1);
    for (int i = 0; i < 24; i++) tick("run24");
    chk("run24.cnt", int'(instr_cnt), 3);

    // HLT at phase 4, park at 5, resume retires it
    for (int n = 0; n < 8 && phase != 3'd4; n++) tick("to_p4");
    c0 = int'(instr_cnt);
    halt = 1; tick("hlt");
    chk("hlt.state", int'(state), 3);
    chk("hlt.phase", int'(phase), 5);
    chk("hlt.cpu_en", int'(cpu_en), 0);
    for (int i = 0; i < 10; i++) tick("hlt_hold");
    chk("hlt_hold.phase", int'(phase), 5);
    run = 1; tick("resume");
    for (int i = 0; i < 3; i++) tick("resume");
    chk("resume.phase", int'(phase), 0);
    chk("resume.cnt", int'(instr_cnt), (c0 + 1) % 16);

    // stop mid-instruction
    for (int n = 0; n < 8 && phase != 3'd2; n++) tick("to_p2");
    c0 = int'(instr_cnt);
    stop = 1; tick("stop");
    for (int i = 0; i < 5; i++) tick("stop_drain");
    chk("stop.state", int'(state), 0);
    chk("stop.phase", int'(phase), 0);
    chk("stop.cnt", int'(instr_cnt), (c0 + 1) % 16);

    // breakpoint at PC 0x0A, then resume without re-trigger
    bp_en = 1; bp_addr = 5'h0A; pc_addr = 5'h03;
    run = 1; tick("bp_run");
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pc_addr = 5'h0A;
      tick("bp_arm");
    end
    tick("bp_hit");
    chk("bp.state", int'(state), 0);
    chk("bp.flag", int'(bp_hit), 1);
    chk("bp.phase", int'(phase), 0);
    run = 1; tick("bp_resume");
    tick("bp_resume");
    chk("bp_resume.state", int'(state), 1);
    chk("bp_resume.flag", int'(bp_hit), 0);
    chk("bp_resume.phase", int'(phase), 1);
    stop = 1; tick("bp_stop");
    for (int n = 0; n < 10 && state != 2'b00; n++) tick("bp_stop");
    bp_en = 0;

    // single step from IDLE phase 0
    c0 = int'(instr_cnt);
    step = 1; tick("step");
    for (int i = 0; i < 7; i++) tick("step_run");
    chk("step.mid_state", int'(state), 2);
    chk("step.mid_phase", int'(phase), 7);
    tick("step_end");
    chk("step.state", int'(state), 0);
    chk("step.phase", int'(phase), 0);
    chk("step.cnt", int'(instr_cnt), (c0 + 1) % 16);

    // run wins over step; then async reset at phase 6
    run = 1; step = 1; tick("run_step");
    chk("run_step.state", int'(state), 1);
    for (int n = 0; n < 8 && phase != 3'd6; n++) tick("to_p6");
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("areset.phase", int'(phase), 0);
    chk("areset.state", int'(state), 0);
    chk("areset.cnt", int'(instr_cnt), 0);
    chk("areset.cpu_en", int'(cpu_en), 0);
    @(negedge clk);
    rst = 1'b1;

    // random command traffic
    bp_addr = 5'h02;
    for (int i = 0; i < 1200; i++) begin
      run  = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 11) == 0);
      step = ($urandom_range(0, 15) == 0);
      halt = ($urandom_range(0, 3) == 0);
      if (i % 50 == 0) bp_en = $urandom_range(0, 1);
      pc_addr = 5'($urandom_range(0, 3));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/run_controller.md
# run_controller

Run-control sequencer for the RISC core. It owns the 3-bit instruction phase counter that drives the instruction controller and produces the clock enable for the PC, IR and AC registers. It handles run, stop, single-step, the HLT instruction and a PC breakpoint, and counts retired instructions. It sits between the external debug/console pins and the core's controller and datapath.

## Interface
Parameters:
- AW, 5, PC/address width
- CW, 16, retired-instruction counter width
- AUTO_RUN, 0, if 1 the state after reset is RUN instead of IDLE

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  one-cycle command pulse: start or resume free-running
- stop  in  1  one-cycle command pulse: stop at the next instruction boundary
- step  in  1  one-cycle command pulse: execute to the next instruction boundary, then stop
- halt  in  1  halt from the instruction controller; valid in phase 4
- bp_en  in  1  breakpoint enable
- bp_addr  in  AW  breakpoint PC value
- pc_addr  in  AW  current PC register value
- phase  out  3  instruction phase to the controller, 0..7
- cpu_en  out  1  register enable for PC/IR/AC; combinational, 1 in RUN or STEP
- state  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11
- halted  out  1  1 while state is HALTED
- bp_hit  out  1  sticky breakpoint flag
- instr_cnt  out  CW  retired-instruction count

## Operation
- Phase advances by 1 mod 8 on every clk with cpu_en=1 and holds otherwise. Phase is never cleared except by reset.
- Boundary: phase==7 with cpu_en=1. The count increments there, modulo 2^CW and wrapping.
- IDLE and HALTED are the only states that accept run and step. In those states run has priority over step. run goes to RUN; step goes to STEP. Both set bp_skip and clear bp_hit.
- RUN:
  - halt=1 at phase 4 goes to HALTED. Phase still advances to 5, so the inc_pc cycle completes.
  - Otherwise, if stop_pend=1 at the boundary, go to IDLE. Phase becomes 0 and stop_pend clears.
  - Otherwise, a breakpoint (bp_en=1, pc_addr==bp_addr, phase==0, bp_skip=0) goes to IDLE and sets bp_hit. Phase holds at 0 because that cycle does not advance.
  - bp_skip clears after the first phase-0 cycle with cpu_en=1.
- STEP: halt at phase 4 goes to HALTED. Otherwise the boundary goes to IDLE with phase 0. Breakpoints and stop_pend are ignored, and stop_pend clears at that boundary.
- HALTED:
  - run resumes at phase 5. Completing phases 5–7 retires the HLT instruction.
  - step runs phases 5–7, then goes to IDLE.
  - stop goes to IDLE with phase unchanged.
- stop in RUN or STEP sets stop_pend. stop in IDLE does nothing.
- Priority inside RUN/STEP: halt > stop_pend > breakpoint.
- A stop on the same cycle as the boundary is honoured at that boundary.

## Timing
- Reset values (asserted asynchronously):
  - phase=0, state=IDLE (RUN if AUTO_RUN=1), cpu_en follows state
  - halted=0, bp_hit=0, instr_cnt=0, stop_pend=0, bp_skip=1
- Commands are sampled on the rising edge. The state changes at that edge and cpu_en follows in the same cycle.
- First active phase comes 1 cycle after the run pulse.
- In RUN, one instruction takes 8 cycles.
- In STEP, the instruction ends on the cycle after the phase-7 cycle, with state=IDLE and phase=0.
- Reset during any state aborts immediately. Partial instructions are discarded and phase returns to 0.
- Back-to-back run pulses in RUN are ignored. A step during RUN is ignored.

## Test plan
- Reset, then pulse run:
  - phase goes 0,1,…,7,0 with cpu_en=1.
  - After 24 cycles, instr_cnt=3.
- HLT: set halt=1 at phase 4:
  - Next cycle: state=HALTED, halted=1, phase=5, cpu_en=0.
  - Hold 10 cycles: phase stays 5.
  - Pulse run: phase 5,6,7,0 and instr_cnt increments by 1.
- Stop mid-instruction: pulse stop at phase 2 in RUN:
  - Phases 3–7 run, then state=IDLE, phase=0.
  - stop_pend clears and instr_cnt increments by exactly 1.
- Breakpoint: bp_en=1, bp_addr=5'h0A, pc_addr reaches 5'h0A at phase 0:
  - state=IDLE, bp_hit=1, phase=0.
  - Pulse run: no re-trigger at the same PC, and bp_hit=0.
- Step from IDLE at phase 0: exactly 8 enabled cycles, then IDLE, phase=0, instr_cnt+1. A run and step pulsed together enter RUN.
- Assert rst low mid-RUN at phase 6: immediately phase=0, state=IDLE, instr_cnt=0, with no dependence on clk.
